// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle fetch/decode/sequencing stage in front of a 16x32
// register bank.
// It fetches one 32-bit instruction over a req/ack handshake.
// It drives the bank read/write addresses, the write control, the write data
// and the PC.
// It captures operands from the bank and results from the external ALU, and
// computes the next PC.
//
// Instruction format: [31:28] opcode, [27:24] rc, [23:20] ra, [19:16] rb,
// [15:0] imm.
//
// Ports:
//   clk, rst          clock (posedge), asynchronous active-high reset
//   imem_req/addr     registered fetch request, fetch address (= pc)
//   imem_ack/data     fetch completion and instruction word
//   reg_a/reg_b/reg_c bank read addresses and write address
//   reg_ctrl          bank write control (IDLE_CTRL = no write)
//   wb_data, pc       bank write data, program counter
//   op_a/op_b         bank read data
//   alu_op/alu_result ALU operation select and result
//   halted, illegal   HALT state flag, sticky undefined-opcode flag
module ctrl_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [2:0]  IDLE_CTRL = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [3:0]  reg_a,
  output logic [3:0]  reg_b,
  output logic [3:0]  reg_c,
  output logic [2:0]  reg_ctrl,
  output logic [31:0] wb_data,
  output logic [31:0] pc,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDL  = 4'h6;
  localparam logic [3:0] OP_LDH  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_JR   = 4'hB;
  localparam logic [3:0] OP_BADC = 4'hC;
  localparam logic [3:0] OP_BADD = 4'hD;
  localparam logic [3:0] OP_BADE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_pc;
  logic        r_req;
  logic [3:0]  r_reg_a;
  logic [3:0]  r_reg_b;
  logic [3:0]  r_reg_c;
  logic [2:0]  r_ctrl;
  logic [31:0] r_wb;
  logic        r_halted;
  logic        r_illegal;

  logic [3:0]  w_opcode;
  logic [15:0] w_imm;
  logic        w_fetch_done;
  logic [31:0] w_beq_target;

  assign w_opcode     = r_instr[31:28];
  assign w_imm        = r_instr[15:0];
  // Handshake only completes while our own request is up; stray acks are ignored.
  assign w_fetch_done = (r_state == S_FETCH) && r_req && imem_ack;
  // pc already points at the next instruction when the branch resolves.
  assign w_beq_target = r_pc + {{16{w_imm[15]}}, w_imm};

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign reg_a     = r_reg_a;
  assign reg_b     = r_reg_b;
  assign reg_c     = r_reg_c;
  assign reg_ctrl  = r_ctrl;
  assign wb_data   = r_wb;
  assign pc        = r_pc;
  assign alu_op    = r_instr[30:28];
  assign halted    = r_halted;
  assign illegal   = r_illegal;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_fetch_done) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_opcode == OP_HALT) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_WB:    w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Datapath registers: fetch latch, operand capture, writeback setup, PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= 32'h0;
      r_op_a    <= 32'h0;
      r_op_b    <= 32'h0;
      r_pc      <= RESET_PC;
      r_req     <= 1'b0;
      r_reg_a   <= 4'h0;
      r_reg_b   <= 4'h0;
      r_reg_c   <= 4'h0;
      r_ctrl    <= IDLE_CTRL;
      r_wb      <= 32'h0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (imem_ack) begin
            r_req   <= 1'b0;
            r_instr <= imem_data;
            r_reg_c <= imem_data[27:24];
            r_reg_a <= imem_data[23:20];
            r_reg_b <= imem_data[19:16];
          end
        end
        S_DECODE: begin
          r_op_a <= op_a;
          r_op_b <= op_b;
          r_pc   <= r_pc + 32'd1;
        end
        S_EXEC: begin
          case (w_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              r_wb   <= alu_result;
              r_ctrl <= 3'b000;
            end
            OP_LDL: begin
              r_wb   <= {16'h0, w_imm};
              r_ctrl <= 3'b001;
            end
            // The bank moves data[15:0] into the upper half itself.
            OP_LDH: begin
              r_wb   <= {16'h0, w_imm};
              r_ctrl <= 3'b010;
            end
            // The bank takes the return address from the pc port.
            OP_CALL: r_ctrl <= 3'b011;
            OP_BADC, OP_BADD, OP_BADE: begin
              r_ctrl    <= IDLE_CTRL;
              r_illegal <= 1'b1;
            end
            OP_HALT: begin
              r_ctrl   <= IDLE_CTRL;
              r_halted <= 1'b1;
            end
            default: r_ctrl <= IDLE_CTRL;
          endcase
        end
        S_WB: begin
          r_ctrl <= IDLE_CTRL;
          // Request the next instruction immediately so FETCH costs one cycle.
          r_req  <= 1'b1;
          case (w_opcode)
            OP_JMP, OP_CALL: r_pc <= {16'h0, w_imm};
            OP_BEQ: begin
              if (r_op_a == r_op_b) begin
                r_pc <= w_beq_target;
              end else begin
                r_pc <= r_pc;
              end
            end
            OP_JR:   r_pc <= r_op_a;
            default: r_pc <= r_pc;
          endcase
        end
        S_HALT: begin
          r_req  <= 1'b0;
          r_ctrl <= IDLE_CTRL;
        end
        default: r_ctrl <= IDLE_CTRL;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit with a behavioural register bank and ALU.
module tb_ctrl_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [3:0]  reg_a, reg_b, reg_c;
  logic [2:0]  reg_ctrl;
  logic [31:0] wb_data, pc;
  logic [31:0] op_a, op_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        halted, illegal;

  int n_checks = 0;
  int n_errors = 0;

  ctrl_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c),
    .reg_ctrl(reg_ctrl), .wb_data(wb_data), .pc(pc),
    .op_a(op_a), .op_b(op_b),
    .alu_op(alu_op), .alu_result(alu_result),
    .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: writes on posedge, read ports refresh on negedge.
  logic [31:0] bank [16] = '{default: 32'h0};
  always @(posedge clk) begin
    case (reg_ctrl)
      3'b000:  bank[reg_c] <= wb_data;
      3'b001:  bank[reg_c][15:0] <= wb_data[15:0];
      3'b010:  bank[reg_c][31:16] <= wb_data[15:0];
      3'b011:  bank[15] <= pc;
      default: ;
    endcase
  end
  always @(negedge clk) begin
    op_a <= bank[reg_a];
    op_b <= bank[reg_b];
  end

  // ALU model.
  always_comb begin
    case (alu_op)
      3'd1:    alu_result = op_a + op_b;
      3'd2:    alu_result = op_a - op_b;
      3'd3:    alu_result = op_a & op_b;
      3'd4:    alu_result = op_a | op_b;
      3'd5:    alu_result = op_a ^ op_b;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic [2:0]  alu;
    logic [3:0]  rc;
    logic [2:0]  ctrl;
    logic        wb_chk;
    logic [31:0] wb;
    logic [31:0] pc_next;
    logic        ill;
    int          reg_idx;
    logic [31:0] reg_val;
  } vec_t;

  vec_t vecs [16];
  time  prev_ack;

  // Fetch one instruction with 'delay' wait states, then check each stage.
  task automatic apply(input vec_t v, input int idx);
    logic [31:0] addr0;
    time t_ack;
    for (int k = 0; k < 50 && !imem_req; k++) @(negedge clk);
    chk($sformatf("v%0d_req_wait", idx), {31'h0, imem_req}, 32'h1);
    addr0 = imem_addr;
    imem_ack = 1'b0;
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req_hold", idx), {31'h0, imem_req}, 32'h1);
      chk($sformatf("v%0d_addr_hold", idx), imem_addr, addr0);
    end
    imem_data = v.instr;
    imem_ack  = 1'b1;
    @(posedge clk);
    t_ack = $time;
    if (prev_ack != 0)
      chk($sformatf("v%0d_cycles", idx), (t_ack - prev_ack) / 10, 32'(4 + v.delay));
    prev_ack = t_ack;
    @(negedge clk);
    imem_ack = 1'b0;
    chk($sformatf("v%0d_dec_ctrl", idx), {29'h0, reg_ctrl}, 32'h7);
    chk($sformatf("v%0d_dec_req", idx), {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    chk($sformatf("v%0d_alu_op", idx), {29'h0, alu_op}, {29'h0, v.alu});
    chk($sformatf("v%0d_exec_ctrl", idx), {29'h0, reg_ctrl}, 32'h7);
    @(negedge clk);
    chk($sformatf("v%0d_wb_rc", idx), {28'h0, reg_c}, {28'h0, v.rc});
    chk($sformatf("v%0d_wb_ctrl", idx), {29'h0, reg_ctrl}, {29'h0, v.ctrl});
    if (v.wb_chk) chk($sformatf("v%0d_wb_data", idx), wb_data, v.wb);
    @(negedge clk);
    chk($sformatf("v%0d_pc", idx), pc, v.pc_next);
    chk($sformatf("v%0d_fetch_ctrl", idx), {29'h0, reg_ctrl}, 32'h7);
    chk($sformatf("v%0d_illegal", idx), {31'h0, illegal}, {31'h0, v.ill});
    if (v.reg_idx >= 0) chk($sformatf("v%0d_bank", idx), bank[v.reg_idx], v.reg_val);
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input int delay, input logic [2:0] alu,
                              input logic [3:0] rc, input logic [2:0] ctrl, input logic wb_chk,
                              input logic [31:0] wb, input logic [31:0] pcn, input logic ill,
                              input int ri, input logic [31:0] rv);
    vec_t v;
    v.instr = instr; v.delay = delay; v.alu = alu; v.rc = rc; v.ctrl = ctrl;
    v.wb_chk = wb_chk; v.wb = wb; v.pc_next = pcn; v.ill = ill;
    v.reg_idx = ri; v.reg_val = rv;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(32'h6100_1234, 0, 3'd6, 4'd1, 3'b001, 1'b1, 32'h0000_1234, 32'h01, 1'b0, -1, 32'h0);
    vecs[1]  = mk(32'h7100_ABCD, 0, 3'd7, 4'd1, 3'b010, 1'b1, 32'h0000_ABCD, 32'h02, 1'b0, 1, 32'hABCD_1234);
    vecs[2]  = mk(32'h6100_0005, 2, 3'd6, 4'd1, 3'b001, 1'b1, 32'h0000_0005, 32'h03, 1'b0, -1, 32'h0);
    vecs[3]  = mk(32'h7100_0000, 0, 3'd7, 4'd1, 3'b010, 1'b1, 32'h0000_0000, 32'h04, 1'b0, 1, 32'h5);
    vecs[4]  = mk(32'h6200_0007, 0, 3'd6, 4'd2, 3'b001, 1'b1, 32'h0000_0007, 32'h05, 1'b0, 2, 32'h7);
    vecs[5]  = mk(32'h1312_0000, 0, 3'd1, 4'd3, 3'b000, 1'b1, 32'd12,        32'h06, 1'b0, 3, 32'd12);
    vecs[6]  = mk(32'h2421_0000, 1, 3'd2, 4'd4, 3'b000, 1'b1, 32'd2,         32'h07, 1'b0, 4, 32'd2);
    vecs[7]  = mk(32'h3512_0000, 0, 3'd3, 4'd5, 3'b000, 1'b1, 32'd5,         32'h08, 1'b0, 5, 32'd5);
    vecs[8]  = mk(32'h8000_0010, 0, 3'd0, 4'd0, 3'b111, 1'b0, 32'h0,         32'h10, 1'b0, -1, 32'h0);
    vecs[9]  = mk(32'h9011_FFFE, 0, 3'd1, 4'd0, 3'b111, 1'b0, 32'h0,         32'h0F, 1'b0, -1, 32'h0);
    vecs[10] = mk(32'h0000_0000, 0, 3'd0, 4'd0, 3'b111, 1'b0, 32'h0,         32'h10, 1'b0, -1, 32'h0);
    vecs[11] = mk(32'h9012_FFFE, 0, 3'd1, 4'd0, 3'b111, 1'b0, 32'h0,         32'h11, 1'b0, -1, 32'h0);
    vecs[12] = mk(32'h8000_0020, 0, 3'd0, 4'd0, 3'b111, 1'b0, 32'h0,         32'h20, 1'b0, -1, 32'h0);
    vecs[13] = mk(32'hA000_0040, 0, 3'd2, 4'd0, 3'b011, 1'b0, 32'h0,         32'h40, 1'b0, 15, 32'h21);
    vecs[14] = mk(32'hB0F0_0000, 0, 3'd3, 4'd0, 3'b111, 1'b0, 32'h0,         32'h21, 1'b0, -1, 32'h0);
    vecs[15] = mk(32'hC300_1111, 0, 3'd4, 4'd3, 3'b111, 1'b0, 32'h0,         32'h22, 1'b1, 3, 32'd12);

    prev_ack  = 0;
    rst       = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'h6100_1234;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ctrl", {29'h0, reg_ctrl}, 32'h7);
    chk("rst_wb", wb_data, 32'h0);
    chk("rst_regs", {20'h0, reg_a, reg_b, reg_c}, 32'h0);
    chk("rst_flags", {30'h0, halted, illegal}, 32'h0);

    // Release reset with ack already high: request appears one cycle later.
    rst = 1'b0;
    #1 chk("rel_req_low", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    chk("rel_req_high", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Wait states, then reset in the middle of the outstanding fetch.
    for (int k = 0; k < 50 && !imem_req; k++) @(negedge clk);
    imem_ack = 1'b0;
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      chk("wait_req", {31'h0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, 32'h22);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_illegal", {31'h0, illegal}, 32'h0);
    imem_data = 32'h1312_0000;
    imem_ack  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack_ignored", {29'h0, reg_ctrl}, 32'h7);
    chk("rst_ack_rc", {28'h0, reg_c}, 32'h0);
    rst = 1'b0;
    #1 chk("rel2_req_low", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    chk("rel2_req_high", {31'h0, imem_req}, 32'h1);
    chk("rel2_rc", {28'h0, reg_c}, 32'h0);

    // HALT: fetched with ack held high throughout.
    imem_data = 32'hF000_0000;
    @(negedge clk);
    chk("halt_dec_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    chk("halt_pc", pc, 32'h1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("halt_req", {31'h0, imem_req}, 32'h0);
      chk("halt_pc_frozen", pc, 32'h1);
      chk("halt_ctrl", {29'h0, reg_ctrl}, 32'h7);
    end
    imem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
Multi-cycle fetch/decode/sequencing stage that sits directly upstream of the 16x32 register bank. It fetches 32-bit instructions over a req/ack handshake and decodes them. It drives the bank's read addresses, write address, 3-bit write control, write data and PC, captures operands from the bank and results from the external ALU, and computes the next PC.
Instruction format: [31:28] opcode, [27:24] rc, [23:20] ra, [19:16] rb, [15:0] imm.

Parameters:
RESET_PC, 32'h0, PC value loaded on reset (word address).
IDLE_CTRL, 3'b111, bank control code meaning "no write".

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request, registered
imem_addr  out  32  fetch address, always equals pc
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  32  fetched instruction
reg_a, reg_b  out  4  bank read addresses (ra, rb of latched instruction)
reg_c  out  4  bank write address (rc)
reg_ctrl  out  3  bank write control: 000 full, 001 low half, 010 high half, 011 write pc to r15, IDLE_CTRL none
wb_data  out  32  bank write data
pc  out  32  program counter, also bank pc input
op_a, op_b  in  32  bank read outputs (updated by bank on negedge)
alu_op  out  3  opcode[2:0] to ALU
alu_result  in  32  combinational ALU result of op_a/op_b
halted  out  1  high in HALT state
illegal  out  1  sticky, set on undefined opcode

Behaviour:
- Reset (async, any state, mid-fetch included): state=FETCH, pc=RESET_PC, imem_req=0, instr=0, reg_a/b/c=0, reg_ctrl=IDLE_CTRL, wb_data=0, halted=0, illegal=0. An in-flight fetch is abandoned; an ack arriving during reset is ignored.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT is terminal until reset.
- FETCH:
  - imem_req<=1 on the first posedge in FETCH.
  - On a posedge with imem_req=1 and imem_ack=1: latch imem_data, imem_req<=0, go to DECODE.
  - Ack with req=0 is ignored. Wait states are unbounded.
  - Minimum 4 cycles per instruction: req cycle with ack, DECODE, EXEC, WB.
- DECODE: reg_a/reg_b/reg_c valid from the latched instruction. The bank updates op_a/op_b on the negedge. At the closing posedge: capture op_a/op_b, pc<=pc+1.
- EXEC: alu_op=opcode[2:0]. At the closing posedge, load wb_data and reg_ctrl for the WB cycle:
  - 0 NOP: IDLE_CTRL.
  - 1 ADD / 2 SUB / 3 AND / 4 OR / 5 XOR: wb_data=alu_result, ctrl 000.
  - 6 LDL: wb_data={16'h0,imm}, ctrl 001 (bank keeps the upper half).
  - 7 LDH: wb_data={16'h0,imm}, ctrl 010. The bank places data[15:0] into the upper half.
  - 8 JMP / 9 BEQ / B JR: IDLE_CTRL.
  - A CALL: ctrl 011; the bank writes the pc port (already pc+1) into r15.
  - F HALT: IDLE_CTRL, next state HALT.
  - C, D, E: treated as NOP, illegal<=1.
- WB: reg_ctrl is held for exactly this one cycle; the bank writes at its closing posedge. At the same posedge, reg_ctrl<=IDLE_CTRL and the PC update happens:
  - JMP, CALL: pc<={16'h0,imm}.
  - BEQ: if captured op_a==op_b, pc<=pc+sext(imm) (relative to pc+1); else pc is unchanged.
  - JR: pc<=captured op_a.
- PC arithmetic is 32-bit modulo. 32'hFFFFFFFF+1 wraps to 0; negative BEQ offsets wrap likewise.
- HALT: imem_req=0, reg_ctrl=IDLE_CTRL, pc frozen, halted=1. Ignores imem_ack.
- reg_ctrl is IDLE_CTRL in every cycle except WB. The bank is never written during FETCH, DECODE or EXEC.

Test Plan:
- Reset then ack held high: imem_req rises 1 cycle after rst falls. Instr 0x6100_1234 (LDL r1), then 0x7100_ABCD (LDH r1) -> r1=0xABCD1234; each instruction takes 4 cycles.
- ADD: r1=5, r2=7, instr 0x1312_0000 -> alu_op=001, WB cycle shows reg_c=3, reg_ctrl=000, wb_data=12.
- BEQ at pc=0x10 with imm=0xFFFE and equal operands -> pc becomes 0x0F; with unequal operands -> pc becomes 0x11.
- CALL imm=0x0040 at pc=0x20 -> r15=0x21, pc=0x40. Then JR r15 -> pc=0x21.
- Ack delayed 3 cycles: imem_req stays high and imem_addr stable. Assert rst mid-wait -> imem_req=0 immediately, pc=RESET_PC, a late ack is ignored.
- Opcode 0xC -> illegal=1 and no bank write. HALT 0xF000_0000 -> halted=1, imem_req stays 0 for 20 cycles, and pc is frozen.
